// File: rtl/ads1675_pkg.sv
// rtl/ads1675_pkg.sv - shared state type, default widths and sign extension for the ADS1675 receiver
package ads1675_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_DRDY, SHIFT, PUSH} rx_state_t;

  localparam int DEF_DATA_W = 24;
  localparam int DEF_OUT_W  = 32;

  function automatic logic [DEF_OUT_W-1:0] sign_ext(input logic [DEF_DATA_W-1:0] v);
    return {{(DEF_OUT_W-DEF_DATA_W){v[DEF_DATA_W-1]}}, v};
  endfunction

endpackage

// File: rtl/ads1675_rx_sync.sv
// rtl/ads1675_rx_sync.sv - flop-chain synchronizer with configurable depth and reset value
module ads1675_rx_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/ads1675_rx.sv
// rtl/ads1675_rx.sv - ADS1675 SCLK/DRDY/DOUT capture to a 1-entry AXI-Stream output register
// Optional ADS1675_RX_TEST_PATTERN_EN adds test_mode, replacing DOUT frames by an internal ramp.
module ads1675_rx
  import ads1675_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int CLK_DIV     = 2,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 enable,
`ifdef ADS1675_RX_TEST_PATTERN_EN
  input  logic                 test_mode,
`endif
  output logic                 sclk_o,
  input  logic                 drdy_i,
  input  logic                 dout_i,
  output logic [OUT_W-1:0]     m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 overflow,
  output logic [ERR_CNT_W-1:0] overflow_cnt,
  output logic [ERR_CNT_W-1:0] frame_err_cnt
);

  localparam int DIV_W = ($clog2(CLK_DIV) > 0) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(DATA_W + 1);

  rx_state_t          state;
  logic [DIV_W-1:0]   div_cnt;
  logic               div_wrap;
  logic [SYNC_STAGES:0] rise_pipe;
  logic               strobe;
  logic               drdy_s, dout_s, drdy_prev, drdy_fall;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DATA_W-1:0]  sr;
  logic [DATA_W-1:0]  push_val;
  logic [OUT_W-1:0]   push_ext;
  logic               pattern;

  ads1675_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_drdy (
    .clk(aclk), .rst(areset), .d(drdy_i), .q(drdy_s)
  );
  ads1675_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_dout (
    .clk(aclk), .rst(areset), .d(dout_i), .q(dout_s)
  );

  assign div_wrap  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign drdy_fall = drdy_prev & ~drdy_s;
  // One extra stage: rise_pipe[0] marks the first cycle sclk_o is high, whose DOUT reaches dout_s SYNC_STAGES later.
  assign strobe    = rise_pipe[SYNC_STAGES];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      div_cnt   <= '0;
      sclk_o    <= 1'b0;
      rise_pipe <= '0;
    end else begin
      rise_pipe <= {rise_pipe[SYNC_STAGES-1:0], enable & div_wrap & ~sclk_o};
      if (!enable) begin
        div_cnt <= '0;
        sclk_o  <= 1'b0;
      end else if (div_wrap) begin
        div_cnt <= '0;
        sclk_o  <= ~sclk_o;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

`ifdef ADS1675_RX_TEST_PATTERN_EN
  logic [DATA_W-1:0] ramp;

  assign pattern  = test_mode;
  assign push_val = test_mode ? ramp : sr;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) ramp <= '0;
    else if (enable && state == PUSH && test_mode) ramp <= ramp + 1'b1;
  end
`else
  assign pattern  = 1'b0;
  assign push_val = sr;
`endif

  assign push_ext = {{(OUT_W-DATA_W){push_val[DATA_W-1]}}, push_val};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      sr            <= '0;
      drdy_prev     <= 1'b1;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      overflow      <= 1'b0;
      overflow_cnt  <= '0;
      frame_err_cnt <= '0;
    end else begin
      drdy_prev <= drdy_s;
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
      if (!enable) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: state <= WAIT_DRDY;
          WAIT_DRDY: if (drdy_fall) begin
            bit_cnt <= '0;
            sr      <= '0;
            state   <= pattern ? PUSH : SHIFT;
          end
          SHIFT: if (drdy_fall) begin
            if (frame_err_cnt != '1) frame_err_cnt <= frame_err_cnt + 1'b1;
            bit_cnt <= '0;
            sr      <= '0;
          end else if (strobe) begin
            sr      <= {sr[DATA_W-2:0], dout_s};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(DATA_W - 1)) state <= PUSH;
          end
          PUSH: begin
            // A reload on the handshake cycle overrides the tvalid clear above.
            if (!m_axis_tvalid || m_axis_tready) begin
              m_axis_tdata  <= push_ext;
              m_axis_tvalid <= 1'b1;
            end else begin
              overflow <= 1'b1;
              if (overflow_cnt != '1) overflow_cnt <= overflow_cnt + 1'b1;
            end
            state <= WAIT_DRDY;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
